result_to_bcd: RTL and testbench

RESULT_TO_BCD -- requirements
Module: result_to_bcd

---
 rtl/result_to_bcd_if.sv | 33 +++
 rtl/result_to_bcd.sv | 131 +++++++++++++
 tb/tb_result_to_bcd.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_to_bcd_if.sv
// Handshake bundle for result_to_bcd.
//   master : producer/consumer side (drives in_valid/in_data/in_signed/out_ready)
//   slave  : converter side (drives in_ready/out_valid/out_bcd/out_neg)
// Ports carried:
//   in_valid/in_ready   input handshake
//   in_data[WIDTH]      binary value to convert
//   in_signed           1 = two's complement, 0 = unsigned
//   out_valid/out_ready output handshake
//   out_bcd[4*DIGITS]   packed BCD, digit 0 in bits [3:0]
//   out_neg             converted value was negative
interface result_to_bcd_if #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 7
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  in_signed;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_neg;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_bcd, out_neg
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_bcd, out_neg
  );
endinterface

// File: rtl/result_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// Accepts a WIDTH-bit value (signed or unsigned) in IDLE, runs WIDTH shift
// iterations, then presents the BCD magnitude and sign in DONE until the
// consumer takes it.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : result_to_bcd_if slave (input/output valid-ready handshakes)
//   busy   : high whenever not IDLE
module result_to_bcd #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  result_to_bcd_if.slave       bus,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]    mag;
  logic                neg;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] acc_adj;
  logic [4*DIGITS-1:0] acc_shift;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] bcd_q;
  logic                neg_q;

  logic                in_ready_i;
  logic                accept;
  logic                last_iter;
  logic                neg_in;
  logic [WIDTH-1:0]    mag_in;

  assign accept    = bus.in_valid & in_ready_i;
  assign last_iter = (cnt == CW'(1));

  // Sign/magnitude split; negation is modulo 2^WIDTH so the most negative
  // value maps onto itself, which read as unsigned is the correct magnitude.
  assign neg_in = bus.in_signed & bus.in_data[WIDTH-1];
  assign mag_in = neg_in ? (~bus.in_data + WIDTH'(1)) : bus.in_data;

  // Double-dabble step: correct digits >= 5 before the shift so that each
  // nibble carries cleanly into the next decimal digit.
  always_comb begin
    acc_adj = acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[4*DIGITS-2:0], mag[WIDTH-1]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (last_iter) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready_i    = (state == IDLE);
    bus.in_ready  = in_ready_i;
    bus.out_valid = (state == DONE);
    busy          = (state != IDLE);
  end

  // Datapath. The presented result lives in its own register, loaded only on
  // the final iteration, so out_bcd keeps the last result through IDLE and the
  // next conversion instead of exposing the working accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag   <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      bcd_q <= '0;
      neg_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mag <= mag_in;
            neg <= neg_in;
            acc <= '0;
            cnt <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          acc <= acc_shift;
          mag <= {mag[WIDTH-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (last_iter) begin
            bcd_q <= acc_shift;
            neg_q <= neg & (|acc_shift);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_bcd = bcd_q;
  assign bus.out_neg = neg_q;

endmodule

// File: tb/tb_result_to_bcd.sv
module tb_result_to_bcd;

  localparam int WIDTH  = 20;
  localparam int DIGITS = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  result_to_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  result_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sign/magnitude by integer arithmetic, decimal digits by % 10.
  function automatic void golden(input logic [19:0] d, input logic s,
                                 output logic [27:0] b, output logic n);
    logic [19:0] m;
    int unsigned v;
    n = s & d[19];
    m = n ? (20'd0 - d) : d;
    v = 32'(m);
    b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    if (v != 0 || m == 0) n = 1'b0;
  endfunction

  // Runs one conversion with out_ready held high; returns the captured result,
  // cycles from acceptance to out_valid, out_valid one cycle later, and ok=0 on
  // a timeout. Scrambles in_data/in_signed during the conversion.
  task automatic convert(input logic [19:0] d, input logic s,
                         output logic [27:0] bcd, output logic neg,
                         output int lat, output logic vld_after, output logic ok);
    int guard;
    guard = 0;
    ok = 1'b1;
    bus.out_ready = 1'b1;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      step();
      guard++;
    end
    if (bus.in_ready !== 1'b1) ok = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_signed = s;
    step();
    bus.in_valid  = 1'b0;
    bus.in_data   = ~d;
    bus.in_signed = ~s;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    if (bus.out_valid !== 1'b1) ok = 1'b0;
    bcd = bus.out_bcd;
    neg = bus.out_neg;
    step();
    vld_after = bus.out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 20'h12345;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({bus.in_ready, bus.out_valid, busy, bus.out_neg} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/vld/busy/neg=%b required 1000",
               {bus.in_ready, bus.out_valid, busy, bus.out_neg});
    end
    checks++;
    if (bus.out_bcd !== 28'h0) begin
      errors++;
      $display("FAIL reset_bcd: got %h required 0000000", bus.out_bcd);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if ({bus.in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got rdy/busy=%b required 10", {bus.in_ready, busy});
    end
  endtask

  task automatic test_unsigned();
    logic [27:0] b;
    logic n, va, ok;
    int lat;
    convert(20'h0001E, 1'b0, b, n, lat, va, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL unsigned_timeout: got ok=%b required 1", ok); end
    checks++;
    if (b !== 28'h0000030) begin errors++; $display("FAIL unsigned_bcd: got %h required 0000030", b); end
    checks++;
    if (n !== 1'b0) begin errors++; $display("FAIL unsigned_neg: got %b required 0", n); end
    checks++;
    if (lat !== 20) begin errors++; $display("FAIL unsigned_latency: got %0d required 20", lat); end
    checks++;
    if (va !== 1'b0) begin errors++; $display("FAIL unsigned_valid_width: got %b required 0", va); end
  endtask

  task automatic test_signed();
    logic [19:0] dv [3];
    logic [27:0] eb [3];
    logic        en [3];
    logic [27:0] b;
    logic n, va, ok;
    int lat;
    dv[0] = 20'hFFFFE; eb[0] = 28'h0000002; en[0] = 1'b1;
    dv[1] = 20'hFFFFF; eb[1] = 28'h0000001; en[1] = 1'b1;
    dv[2] = 20'h7FFFF; eb[2] = 28'h0524287; en[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      convert(dv[i], 1'b1, b, n, lat, va, ok);
      checks++;
      if ({ok, n, b} !== {1'b1, en[i], eb[i]}) begin
        errors++;
        $display("FAIL signed_%0d: got ok=%b neg=%b bcd=%h required ok=1 neg=%b bcd=%h",
                 i, ok, n, b, en[i], eb[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    logic [19:0] dv [5];
    logic        sv [5];
    logic [27:0] eb [5];
    logic        en [5];
    logic [27:0] b;
    logic n, va, ok;
    int lat;
    dv[0] = 20'hFFFFF; sv[0] = 1'b0; eb[0] = 28'h1048575; en[0] = 1'b0;
    dv[1] = 20'h80000; sv[1] = 1'b1; eb[1] = 28'h0524288; en[1] = 1'b1;
    dv[2] = 20'h00000; sv[2] = 1'b0; eb[2] = 28'h0000000; en[2] = 1'b0;
    dv[3] = 20'h00000; sv[3] = 1'b1; eb[3] = 28'h0000000; en[3] = 1'b0;
    dv[4] = 20'h80000; sv[4] = 1'b0; eb[4] = 28'h0524288; en[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      convert(dv[i], sv[i], b, n, lat, va, ok);
      checks++;
      if ({ok, n, b} !== {1'b1, en[i], eb[i]}) begin
        errors++;
        $display("FAIL boundary_%0d: got ok=%b neg=%b bcd=%h required ok=1 neg=%b bcd=%h",
                 i, ok, n, b, en[i], eb[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    lat = 0;
    while (bus.in_ready !== 1'b1 && lat < 100) begin step(); lat++; end
    bus.in_valid  = 1'b1;
    bus.in_data   = 20'h03039;
    bus.in_signed = 1'b0;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin step(); lat++; end
    checks++;
    if (lat !== 20) begin errors++; $display("FAIL bp_latency: got %0d required 20", lat); end
    bus.in_valid  = 1'b1;
    bus.in_data   = 20'h000FF;
    bus.in_signed = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_neg, bus.out_bcd} !== {3'b100, 28'h0012345}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got vld/rdy/neg=%b bcd=%h required 100 bcd=0012345",
                 c, {bus.out_valid, bus.in_ready, bus.out_neg}, bus.out_bcd);
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if ({bus.out_valid, bus.in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release: got vld/rdy/busy=%b required 010",
               {bus.out_valid, bus.in_ready, busy});
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.in_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL bp_accept: got rdy/busy=%b required 01", {bus.in_ready, busy});
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin step(); lat++; end
    checks++;
    if ({lat, bus.out_neg, bus.out_bcd} !== {32'd20, 1'b0, 28'h0000255}) begin
      errors++;
      $display("FAIL bp_second: got lat=%0d neg=%b bcd=%h required lat=20 neg=0 bcd=0000255",
               lat, bus.out_neg, bus.out_bcd);
    end
    step();
  endtask

  task automatic test_reset_mid_shift();
    int  lat;
    logic seen;
    bus.out_ready = 1'b1;
    lat = 0;
    while (bus.in_ready !== 1'b1 && lat < 100) begin step(); lat++; end
    bus.in_valid  = 1'b1;
    bus.in_data   = 20'h54321;
    bus.in_signed = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (9) step();
    checks++;
    if ({busy, bus.out_valid, bus.out_bcd} !== {2'b10, 28'h0000255}) begin
      errors++;
      $display("FAIL abort_pre: got busy/vld=%b bcd=%h required 10 bcd=0000255",
               {busy, bus.out_valid}, bus.out_bcd);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({bus.out_valid, bus.in_ready, busy, bus.out_neg, bus.out_bcd} !== {4'b0100, 28'h0}) begin
      errors++;
      $display("FAIL abort_state: got vld/rdy/busy/neg=%b bcd=%h required 0100 bcd=0000000",
               {bus.out_valid, bus.in_ready, busy, bus.out_neg}, bus.out_bcd);
    end
    seen = 1'b0;
    repeat (40) begin
      step();
      seen = seen | bus.out_valid;
    end
    checks++;
    if ({seen, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL abort_no_output: got seen/rdy=%b required 01", {seen, bus.in_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] exp_b [$];
    logic        exp_n [$];
    logic [27:0] eb;
    logic        en;
    logic [19:0] d;
    logic        s;
    logic        pend, accepted;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; pend = 1'b0;
    d = '0; s = 1'b0;
    bus.in_valid = 1'b0;
    while ((sent < 1000 || exp_b.size() > 0) && cyc < 80000) begin
      if (!pend && sent < 1000) begin
        d = 20'($urandom);
        s = 1'($urandom);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_signed = s;
        pend = 1'b1;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: got output %h with none outstanding required none", bus.out_bcd);
        end else begin
          eb = exp_b.pop_front();
          en = exp_n.pop_front();
          if ({bus.out_neg, bus.out_bcd} !== {en, eb}) begin
            errors++;
            $display("FAIL b2b_result_%0d: got neg=%b bcd=%h required neg=%b bcd=%h",
                     recv, bus.out_neg, bus.out_bcd, en, eb);
          end
          recv++;
        end
      end
      accepted = pend & (bus.in_ready === 1'b1);
      if (accepted) begin
        golden(d, s, eb, en);
        exp_b.push_back(eb);
        exp_n.push_back(en);
        sent++;
      end
      step();
      cyc++;
      if (accepted) begin
        pend = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 20'($urandom);
        bus.in_signed = 1'($urandom);
      end
    end
    checks++;
    if (sent !== 1000 || recv !== 1000) begin
      errors++;
      $display("FAIL b2b_count: got sent=%0d recv=%0d required 1000/1000", sent, recv);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_boundaries();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
